// File: rtl/third_stage_pkg.sv
// Types shared by the modular adder third stage and its selector.
// State encodings come from the common defines header.
`include "modadd_defs.vh"

package third_stage_pkg;

  localparam int DEF_WIDTH = `MODADD_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = `ST_EMPTY,
    ONE   = `ST_ONE,
    FULL  = `ST_FULL
  } state_t;

endpackage

// File: rtl/modadd_defs.vh
// Shared defaults for the modular adder pipeline: residue width and
// the third-stage FIFO state encodings.
`ifndef MODADD_DEFS_VH
`define MODADD_DEFS_VH

`define MODADD_WIDTH 4

`define ST_EMPTY 2'd0
`define ST_ONE   2'd1
`define ST_FULL  2'd2

`endif

// File: rtl/third_stage_result_select.sv
// Final residue select between the w and v sums, plus the range check
// done once at push time.
module result_select #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 15
) (
  input  logic             s,
  input  logic [WIDTH:0]   w,
  input  logic [WIDTH:0]   v,
  input  logic             b4,
  output logic [WIDTH-1:0] value,
  output logic             err
);

  logic sel;

  assign sel   = s ? ~b4 : w[WIDTH];
  assign value = sel ? v[WIDTH-1:0] : w[WIDTH-1:0];
  assign err   = 32'(value) >= 32'(MODULUS);

endmodule

// File: rtl/third_stage.sv
// Third stage of the modular adder: residue select feeding a 2-entry
// valid/ready FIFO with a pop counter.
`include "modadd_defs.vh"

module third_stage #(
  parameter int WIDTH   = `MODADD_WIDTH,
  parameter int MODULUS = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s,
  input  logic [WIDTH:0]   w,
  input  logic [WIDTH:0]   v,
  input  logic             b4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             range_err,
  output logic [7:0]       op_count
);

  import third_stage_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] new_res;
  logic             new_err;
  logic [WIDTH-1:0] head_res;
  logic             head_err;
  logic [WIDTH-1:0] tail_res;
  logic             tail_err;
  logic             push;
  logic             pop;

  result_select #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_sel (
    .s     (s),
    .w     (w),
    .v     (v),
    .b4    (b4),
    .value (new_res),
    .err   (new_err)
  );

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign result    = out_valid ? head_res : '0;
  assign range_err = out_valid & head_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head_res  <= '0;
      head_err  <= 1'b0;
      tail_res  <= '0;
      tail_err  <= 1'b0;
      op_count  <= 8'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (pop)
        op_count <= op_count + 8'd1;
      unique case (state)
        EMPTY: begin
          if (push) begin
            head_res  <= new_res;
            head_err  <= new_err;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          // push+pop replaces the head in place
          if (push && pop) begin
            head_res <= new_res;
            head_err <= new_err;
          end else if (push) begin
            tail_res <= new_res;
            tail_err <= new_err;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (pop) begin
            head_res  <= '0;
            head_err  <= 1'b0;
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            head_res <= tail_res;
            head_err <= tail_err;
            tail_res <= '0;
            tail_err <= 1'b0;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_third_stage.sv
// Directed bench for third_stage: selection vectors, backpressure,
// streaming throughput and asynchronous reset.
module tb_third_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       s;
  logic [4:0] w;
  logic [4:0] v;
  logic       b4;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       range_err;
  logic [7:0] op_count;

  int n_vec = 0;
  int n_err = 0;

  third_stage #(.WIDTH(4), .MODULUS(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .w         (w),
    .v         (v),
    .b4        (b4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .range_err (range_err),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // push one entry into an empty FIFO, check it at head, then pop it
  task automatic one_vec(input string tag, input logic ts,
                         input logic [4:0] tw, input logic [4:0] tv,
                         input logic tb, input logic [3:0] er,
                         input logic ee);
    s = ts; w = tw; v = tv; b4 = tb;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    w = 5'h1f; v = 5'h1f; s = ~ts;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_err"}, 32'(range_err), 32'(ee));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    s = 1'b0; w = '0; v = '0; b4 = 1'b0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_res", 32'(result), 32'd0);
    check("rst_err", 32'(range_err), 32'd0);
    check("rst_cnt", 32'(op_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    one_vec("add",   1'b0, 5'b0_0110, 5'b0_0111, 1'b0, 4'd6,  1'b0);
    one_vec("carry", 1'b0, 5'b1_0010, 5'b1_0011, 1'b0, 4'd3,  1'b0);
    one_vec("max",   1'b0, 5'b0_1111, 5'b1_0000, 1'b0, 4'd15, 1'b1);
    one_vec("sub0",  1'b1, 5'b0_0100, 5'b0_0101, 1'b0, 4'd5,  1'b0);
    one_vec("sub1",  1'b1, 5'b0_0100, 5'b0_0101, 1'b1, 4'd4,  1'b0);
    check("cnt5", 32'(op_count), 32'd5);

    // backpressure: fill, try a third push, then drain
    do_reset();
    check("bp_cnt0", 32'(op_count), 32'd0);
    s = 1'b0; b4 = 1'b0; v = 5'd0;
    in_valid = 1'b1;
    w = 5'd1;
    tick();
    w = 5'd2;
    tick();
    check("bp_full", 32'(in_ready), 32'd0);
    w = 5'd3;
    tick();
    in_valid = 1'b0;
    check("bp_ignored", 32'(in_ready), 32'd0);
    check("bp_head1", 32'(result), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_head2", 32'(result), 32'd2);
    check("bp_one", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b0;
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_cnt2", 32'(op_count), 32'd2);

    // streaming: push+pop every cycle keeps exactly one entry
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      w = 5'(i % 16);
      tick();
      check("st_res", 32'(result), 32'(i % 16));
      check("st_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("st_empty", 32'(out_valid), 32'd0);
    check("st_cnt", 32'(op_count), 32'd44);

    // asynchronous reset with a full FIFO
    in_valid = 1'b1;
    w = 5'd9;
    tick();
    w = 5'd10;
    tick();
    in_valid = 1'b0;
    check("ar_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ready", 32'(in_ready), 32'd1);
    check("ar_cnt", 32'(op_count), 32'd0);
    check("ar_res", 32'(result), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    w = 5'd7;
    tick();
    in_valid = 1'b0;
    check("ar_first_v", 32'(out_valid), 32'd1);
    check("ar_first_r", 32'(result), 32'd7);
    check("ar_first_c", 32'(op_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
